mc_control_unit: RTL

Multicycle RV32I control FSM with memory wait-state handshake, bus-timeout and illegal-opcode trapping, and a retired-instruction counter. Sits between the datapath (PC, IR, register file, ALU, ALUOut) and a variable-latency unified memory port. Generalises the fixed-latency controller with ready-driven stalls, complete JALR/LUI/AUIPC sequencing, 2-bit `pc_source` and parametrised counters.

---
 rtl/mc_control_unit_pkg.sv | 68 ++++++
 rtl/mc_control_unit_if.sv | 18 +
 rtl/mc_wait_timer.sv | 28 ++
 rtl/mc_control_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_unit_pkg.sv
// mc_ctrl_pkg: shared types and constants for the multicycle RV32I controller.
//   - state_t      : controller FSM states (S_MULWAIT only with MC_CTRL_MULDIV_EN)
//   - OP_*         : RV32I major opcodes (IR[6:0])
//   - ALUOP_*, SRC_A_*, SRC_B_*, PCSRC_* : datapath select encodings
//   - CAUSE_*      : trap cause codes
// Optional feature macro: MC_CTRL_MULDIV_EN adds the multiply/divide wait state.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_AUIPC,
    S_LUI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALR_LINK,
    S_TRAP
`ifdef MC_CTRL_MULDIV_EN
    , S_MULWAIT
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC  = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // States that hold a memory access open and therefore run the wait timer.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: unified memory port between controller and memory.
//   memory_read / memory_write / lorD : access request from the controller
//   mem_ready                         : completion from the memory
// Handshake: the controller holds its request strobe steady for as long as
// the access is open; the access completes on any rising clock edge where
// mem_ready is high while a strobe is asserted. mem_ready outside an open
// access has no effect.
interface mc_control_unit_if;
  logic memory_read;
  logic memory_write;
  logic lorD;
  logic mem_ready;

  modport master (output memory_read, output memory_write, output lorD,
                  input  mem_ready);
  modport slave  (input  memory_read, input  memory_write, input  lorD,
                  output mem_ready);
endinterface

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: wait-state counter for open memory accesses.
//   clr     : synchronous clear (has priority over inc)
//   inc     : count one wait cycle
//   expired : counter sits at TIMEOUT-1 (never when TIMEOUT == 0)
module mc_wait_timer #(
  parameter int TIMEOUT = 64,
  parameter int TMO_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [TMO_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count_q <= '0;
    else if (clr) count_q <= '0;
    else if (inc) count_q <= count_q + TMO_W'(1);
  end

  assign expired = (TIMEOUT != 0) && (count_q == LIMIT);

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle RV32I control FSM with variable-latency memory,
// bus timeout and illegal-opcode traps, and a retired-instruction counter.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   mem (master modport)       memory_read/memory_write/lorD out, mem_ready in
//   instruction_opcode/funct7  IR fields
//   trap_ack, muldiv_done      leave TRAP / mul-div result valid
//   datapath strobes & selects pc_write ... alu_src_b
//   muldiv_start, trap, trap_cause, instr_retired, retire_count
//   state_dbg                  current FSM state
// Optional feature macro: MC_CTRL_MULDIV_EN (R-type funct7=0000001 waits in
// S_MULWAIT for muldiv_done).
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TMO_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mc_control_unit_if.master  mem,
  input  logic [6:0]         instruction_opcode,
  input  logic [6:0]         instruction_funct7,
  input  logic               trap_ack,
  input  logic               muldiv_done,
  output logic               pc_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               pc_write_cond,
  output logic               memory_to_reg,
  output logic               is_immediate,
  output logic [1:0]         pc_source,
  output logic [1:0]         aluop,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               muldiv_start,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic               instr_retired,
  output logic [CNT_W-1:0]   retire_count,
  output state_t             state_dbg
);

  state_t     state_q, state_d;
  logic [1:0] cause_d;
  logic [1:0] trap_cause_q;
  logic [CNT_W-1:0] retire_q;
  logic       tmo_expired;
  logic       mem_rd, mem_wr, lor_d;

  // Wait timer restarts whenever the state changes, so every FETCH, MEMREAD
  // and MEMWRITE begins counting from zero.
  mc_wait_timer #(.TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_d != state_q),
    .inc     (is_wait_state(state_q) && !mem.mem_ready),
    .expired (tmo_expired)
  );

`ifdef MC_CTRL_MULDIV_EN
  logic is_muldiv;
  assign is_muldiv = (instruction_opcode == OP_RTYPE) &&
                     (instruction_funct7 == FUNCT7_MULDIV);
`else
  logic unused_muldiv;
  assign unused_muldiv = (^instruction_funct7) ^ muldiv_done;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next state. mem_ready is tested before the timeout so a completion on the
  // expiry cycle still advances normally.
  always_comb begin
    state_d = state_q;
    cause_d = CAUSE_NONE;
    unique case (state_q)
      S_FETCH: begin
        if (mem.mem_ready) state_d = S_DECODE;
        else if (tmo_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        unique case (instruction_opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_AUIPC:          state_d = S_AUIPC;
          OP_LUI:            state_d = S_LUI;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:   state_d = (instruction_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem.mem_ready) state_d = S_MEMWB;
        else if (tmo_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem.mem_ready) state_d = S_FETCH;
        else if (tmo_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
`ifdef MC_CTRL_MULDIV_EN
      S_EXECUTER: state_d = is_muldiv ? S_MULWAIT : S_ALUWB;
      S_MULWAIT:  if (muldiv_done) state_d = S_ALUWB;
`else
      S_EXECUTER: state_d = S_ALUWB;
`endif
      S_EXECUTEI, S_AUIPC, S_LUI: state_d = S_ALUWB;
      S_ALUWB, S_BRANCH, S_JAL, S_JALR_LINK: state_d = S_FETCH;
      S_JALR:     state_d = S_JALR_LINK;
      S_TRAP:     if (trap_ack) state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Outputs: Moore decode of state, with FETCH's PC/IR writes and MEMWRITE's
  // retirement qualified by mem_ready.
  always_comb begin
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    lor_d         = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    pc_write_cond = 1'b0;
    memory_to_reg = 1'b0;
    is_immediate  = 1'b0;
    pc_source     = PCSRC_ALU;
    aluop         = ALUOP_ADD;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    muldiv_start  = 1'b0;
    trap          = 1'b0;
    instr_retired = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRC_B_FOUR;
        pc_write  = mem.mem_ready;
        ir_write  = mem.mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMADR: begin
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_IMM;
        is_immediate = 1'b1;
      end
      S_MEMREAD: begin
        mem_rd = 1'b1;
        lor_d  = 1'b1;
      end
      S_MEMWB: begin
        reg_write     = 1'b1;
        memory_to_reg = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEMWRITE: begin
        mem_wr        = 1'b1;
        lor_d         = 1'b1;
        instr_retired = mem.mem_ready;
      end
      S_EXECUTER: begin
        aluop     = ALUOP_FUNCT;
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
`ifdef MC_CTRL_MULDIV_EN
        muldiv_start = is_muldiv;
`endif
      end
`ifdef MC_CTRL_MULDIV_EN
      S_MULWAIT: begin
        aluop     = ALUOP_FUNCT;
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
      end
`endif
      S_EXECUTEI: begin
        aluop        = ALUOP_FUNCT;
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_IMM;
        is_immediate = 1'b1;
      end
      S_AUIPC: begin
        alu_src_a    = SRC_A_OLDPC;
        alu_src_b    = SRC_B_IMM;
        is_immediate = 1'b1;
      end
      S_LUI: begin
        alu_src_a    = SRC_A_ZERO;
        alu_src_b    = SRC_B_IMM;
        is_immediate = 1'b1;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_BRANCH: begin
        aluop         = ALUOP_BRANCH;
        alu_src_a     = SRC_A_RS1;
        alu_src_b     = SRC_B_RS2;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_retired = 1'b1;
      end
      S_JAL, S_JALR_LINK: begin
        alu_src_a     = SRC_A_OLDPC;
        alu_src_b     = SRC_B_FOUR;
        reg_write     = 1'b1;
        pc_write      = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_retired = 1'b1;
      end
      S_JALR: begin
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_IMM;
        is_immediate = 1'b1;
      end
      S_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  // Cause latches on entry to TRAP and holds until the next trap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      trap_cause_q <= CAUSE_NONE;
    else if (state_d == S_TRAP && state_q != S_TRAP)
      trap_cause_q <= cause_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             retire_q <= '0;
    else if (instr_retired) retire_q <= retire_q + CNT_W'(1);
  end

  assign mem.memory_read  = mem_rd;
  assign mem.memory_write = mem_wr;
  assign mem.lorD         = lor_d;
  assign trap_cause       = trap_cause_q;
  assign retire_count     = retire_q;
  assign state_dbg        = state_q;

endmodule
